ibex_multdiv_iter: RTL and testbench

IBEX_MULTDIV_ITER -- requirements
Module: ibex_multdiv_iter

---
 rtl/ibex_multdiv_iter.sv | 174 +++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
// Iterative 32-bit multiplier/divider that borrows the shared ALU adder.
// Multiply is shift-add over 32 cycles; divide is restoring over 32 cycles.
module ibex_multdiv_iter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        multdiv_en_o,
  output logic [31:0] multdiv_result_o,
  output logic        valid_o
);

  typedef enum logic [2:0] {IDLE, ABS, ITER, SIGN_FIX, FINISH} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} md_op_e;

  state_e      state_q, state_d;
  md_op_e      op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] acc_q, acc_d, lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic        is_mult_q, is_mult_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;

  logic [32:0] sum, a_ext, b_ext, acc_ext, rem_sh, prod, diff;
  logic [31:0] fix_val;
  logic        carry, a_neg, b_neg, op_hi, active_en, mul_sub, ge, fix_neg;

  assign sum       = alu_adder_ext_i[32:0];
  assign carry     = alu_adder_ext_i[33];
  assign a_ext     = {sign_a_q & op_a_q[31], op_a_q};
  assign b_ext     = {sign_b_q & op_b_q[31], op_b_q};
  assign a_neg     = a_ext[32];
  assign b_neg     = b_ext[32];
  assign op_hi     = (op_q == OP_MULH) || (op_q == OP_REM);
  assign active_en = is_mult_q ? mult_en_i : div_en_i;
  assign acc_ext   = {sign_a_q & acc_q[31], acc_q};
  assign rem_sh    = {acc_q, lo_q[31]};

  // The adder only adds; x - y is formed as ~(~x + y) so no carry-in is needed.
  assign mul_sub   = sign_b_q && (cnt_q == 5'd0) && lo_q[0];
  assign prod      = mul_sub ? ~sum : sum;
  // A negative divisor is added rather than subtracted, which yields r - |B| directly.
  assign ge        = b_neg ? carry : ~carry;
  assign diff      = b_neg ? sum : ~sum;
  assign fix_val   = op_hi ? acc_q : lo_q;
  assign fix_neg   = op_hi ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d         = state_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    acc_d           = acc_q;
    lo_d            = lo_q;
    result_d        = result_q;
    is_mult_d       = is_mult_q;
    sign_a_d        = sign_a_q;
    sign_b_d        = sign_b_q;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    multdiv_en_o    = 1'b0;
    valid_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mult_en_i || div_en_i) begin
          is_mult_d = mult_en_i;
          op_d      = md_op_e'(operator_i);
          sign_a_d  = signed_mode_i[0];
          sign_b_d  = signed_mode_i[1];
          op_a_d    = op_a_i;
          op_b_d    = op_b_i;
          acc_d     = '0;
          lo_d      = mult_en_i ? op_b_i : op_a_i;
          cnt_d     = 5'd31;
          if (mult_en_i) begin
            state_d = ITER;
          end else if (op_b_i == '0) begin
            state_d  = FINISH;
            result_d = (md_op_e'(operator_i) == OP_REM) ? op_a_i : 32'hFFFF_FFFF;
          end else begin
            state_d = ABS;
          end
        end
      end
      ABS: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = 33'h1_FFFF_FFFF;
        alu_operand_b_o = {1'b0, lo_q};
        if (a_neg) lo_d = ~sum[31:0];
        cnt_d   = 5'd31;
        state_d = ITER;
      end
      ITER: begin
        multdiv_en_o = 1'b1;
        cnt_d        = cnt_q - 5'd1;
        if (is_mult_q) begin
          alu_operand_a_o = mul_sub ? ~acc_ext : acc_ext;
          alu_operand_b_o = lo_q[0] ? a_ext : 33'd0;
          acc_d           = prod[32:1];
          lo_d            = {prod[0], lo_q[31:1]};
        end else begin
          alu_operand_a_o = b_neg ? rem_sh : ~rem_sh;
          alu_operand_b_o = b_ext;
          acc_d           = ge ? diff[31:0] : rem_sh[31:0];
          lo_d            = {lo_q[30:0], ge};
        end
        if (cnt_q == 5'd0) begin
          state_d = is_mult_q ? FINISH : SIGN_FIX;
          if (is_mult_q) result_d = op_hi ? prod[32:1] : {prod[0], lo_q[31:1]};
        end
      end
      SIGN_FIX: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = 33'h1_FFFF_FFFF;
        alu_operand_b_o = {1'b0, fix_val};
        result_d        = fix_neg ? ~sum[31:0] : fix_val;
        state_d         = FINISH;
      end
      FINISH: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping the request abandons the operation and keeps the last result.
    if ((state_q inside {ABS, ITER, SIGN_FIX}) && !active_en) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= 5'd31;
      op_a_q    <= '0;
      op_b_q    <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      is_mult_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      is_mult_q <= is_mult_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
    end
  end

  assign multdiv_result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: stimulus queues expected results and
// completion cycles; an independent monitor checks them whenever valid_o fires.
module tb_ibex_multdiv_iter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mult_en_i = 1'b0;
  logic        div_en_i = 1'b0;
  logic [1:0]  operator_i = '0;
  logic [1:0]  signed_mode_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [33:0] alu_adder_ext_i;
  logic [32:0] alu_operand_a_o, alu_operand_b_o;
  logic        multdiv_en_o;
  logic [31:0] multdiv_result_o;
  logic        valid_o;

  ibex_multdiv_iter dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mult_en_i        (mult_en_i),
    .div_en_i         (div_en_i),
    .operator_i       (operator_i),
    .signed_mode_i    (signed_mode_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .alu_adder_ext_i  (alu_adder_ext_i),
    .alu_operand_a_o  (alu_operand_a_o),
    .alu_operand_b_o  (alu_operand_b_o),
    .multdiv_en_o     (multdiv_en_o),
    .multdiv_result_o (multdiv_result_o),
    .valid_o          (valid_o)
  );

  // Shared ALU adder model: plain 34-bit sum of the two 33-bit operands.
  assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

  always #5 clk_i = ~clk_i;

  int cycle_cnt = 0;
  always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

  int n_pass  = 0;
  int n_total = 0;

  string       name_q[$];
  logic [31:0] res_q[$];
  int          cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  string       mon_name;
  logic [31:0] mon_res;
  int          mon_cyc;
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (res_q.size() == 0) begin
        check("spurious_valid", valid_o, 0);
      end else begin
        mon_name = name_q.pop_front();
        mon_res  = res_q.pop_front();
        mon_cyc  = cyc_q.pop_front();
        check({mon_name, "_result"}, multdiv_result_o, mon_res);
        check({mon_name, "_cycle"}, cycle_cnt, mon_cyc);
        check({mon_name, "_en_low"}, multdiv_en_o, 0);
      end
    end
  end

  task automatic run_op(input string name, input logic mul, input logic div,
                        input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int start;
    bit got;
    @(posedge clk_i); #1;
    mult_en_i = mul; div_en_i = div; operator_i = op; signed_mode_i = sm;
    op_a_i = a; op_b_i = b;
    start = cycle_cnt;
    name_q.push_back(name); res_q.push_back(exp); cyc_q.push_back(start + lat);
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_i);
      if (valid_o) got = 1;
      else if (cycle_cnt == start + 1) begin
        check({name, "_busy_en"}, multdiv_en_o, 1);
        op_a_i = $urandom; op_b_i = $urandom;
        operator_i = 2'($urandom); signed_mode_i = 2'($urandom);
      end
    end
    if (!got) check({name, "_timeout"}, valid_o, 1);
    @(posedge clk_i); #1;
    mult_en_i = 0; div_en_i = 0;
    @(negedge clk_i);
    check({name, "_hold"}, multdiv_result_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int s;
  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check("rst_valid", valid_o, 0);
    check("rst_en", multdiv_en_o, 0);
    check("rst_result", multdiv_result_o, 0);
    check("rst_alu_a", alu_operand_a_o, 0);
    check("rst_alu_b", alu_operand_b_o, 0);

    // name, mul, div, op, signed_mode, a, b, expected, latency
    run_op("mul_7x6",        1, 0, 2'd0, 2'd0, 32'd7,          32'd6,          32'd42,         33);
    run_op("mulh_m1_ss",     1, 0, 2'd1, 2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33);
    run_op("mulh_m1_uu",     1, 0, 2'd1, 2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
    run_op("mul_m3x5_ss",    1, 0, 2'd0, 2'd3, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33);
    run_op("mulh_su",        1, 0, 2'd1, 2'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33);
    run_op("mulh_us",        1, 0, 2'd1, 2'd2, 32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  33);
    run_op("mulh_min_max",   1, 0, 2'd1, 2'd3, 32'h8000_0000,  32'h7FFF_FFFF,  32'hC000_0000,  33);
    run_op("mul_min_max",    1, 0, 2'd0, 2'd3, 32'h8000_0000,  32'h7FFF_FFFF,  32'h8000_0000,  33);
    run_op("mulh_min_min",   1, 0, 2'd1, 2'd3, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33);
    run_op("mul_priority",   1, 1, 2'd0, 2'd0, 32'd7,          32'd6,          32'd42,         33);
    run_op("div_m7_2",       0, 1, 2'd2, 2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35);
    run_op("rem_m7_2",       0, 1, 2'd3, 2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35);
    run_op("div_7_m2",       0, 1, 2'd2, 2'd3, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35);
    run_op("rem_7_m2",       0, 1, 2'd3, 2'd3, 32'd7,          32'hFFFF_FFFE,  32'd1,          35);
    run_op("divu_max_16",    0, 1, 2'd2, 2'd0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  35);
    run_op("remu_max_16",    0, 1, 2'd3, 2'd0, 32'hFFFF_FFFF,  32'h10,         32'hF,          35);
    run_op("div_100_0",      0, 1, 2'd2, 2'd0, 32'd100,        32'd0,          32'hFFFF_FFFF,  1);
    run_op("rem_100_0",      0, 1, 2'd3, 2'd0, 32'd100,        32'd0,          32'd100,        1);
    run_op("div_ovf",        0, 1, 2'd2, 2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35);
    run_op("rem_ovf",        0, 1, 2'd3, 2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35);

    // Reset in cycle 10 of a multiply: abort, no valid, outputs cleared.
    @(posedge clk_i); #1;
    mult_en_i = 1; operator_i = 2'd0; signed_mode_i = 2'd0; op_a_i = 32'd5; op_b_i = 32'd5;
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0; mult_en_i = 0;
    @(negedge clk_i);
    check("abort_rst_valid", valid_o, 0);
    check("abort_rst_en", multdiv_en_o, 0);
    check("abort_rst_result", multdiv_result_o, 0);
    check("abort_rst_alu_a", alu_operand_a_o, 0);
    check("abort_rst_alu_b", alu_operand_b_o, 0);
    repeat (40) @(negedge clk_i);
    run_op("mul_3x3_after_rst", 1, 0, 2'd0, 2'd0, 32'd3, 32'd3, 32'd9, 33);

    // Divide request dropped in cycle 20: back to IDLE, no valid, result kept.
    @(posedge clk_i); #1;
    div_en_i = 1; operator_i = 2'd2; signed_mode_i = 2'd0; op_a_i = 32'd1000; op_b_i = 32'd7;
    s = cycle_cnt;
    repeat (20) @(posedge clk_i);
    #1 div_en_i = 0;
    check("drop_at_cycle20", cycle_cnt - s, 20);
    @(negedge clk_i);
    @(negedge clk_i);
    check("drop_en_low", multdiv_en_o, 0);
    check("drop_valid_low", valid_o, 0);
    check("drop_result_held", multdiv_result_o, 9);
    repeat (40) @(negedge clk_i);
    run_op("divu_100_7", 0, 1, 2'd2, 2'd0, 32'd100, 32'd7, 32'd14, 35);
    run_op("remu_100_7", 0, 1, 2'd3, 2'd0, 32'd100, 32'd7, 32'd2,  35);

    repeat (5) @(negedge clk_i);
    check("scoreboard_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
